// File: rtl/mdu_pkg.sv
// Shared types and decode helpers for the multiply/divide sequencing controller.
package mdu_pkg;

  // Encoding of the MDU operation presented by EX.
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_MADD  = 4'd3,
    OP_MADDU = 4'd4,
    OP_MSUB  = 4'd5,
    OP_MSUBU = 4'd6,
    OP_MUL   = 4'd7,
    OP_DIV   = 4'd8,
    OP_DIVU  = 4'd9
  } mdu_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DIV_RUN = 2'd2,
    ST_DONE    = 2'd3
  } mdu_state_e;

  // Accumulate select encodings seen by the HI:LO update path.
  localparam logic [1:0] ACC_NONE = 2'd0;
  localparam logic [1:0] ACC_ADD  = 2'd1;
  localparam logic [1:0] ACC_SUB  = 2'd2;

  // Op uses the pipelined multiplier.
  function automatic logic is_mult_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
      OP_MSUB, OP_MSUBU, OP_MUL:             r = 1'b1;
      default:                               r = 1'b0;
    endcase
    return r;
  endfunction

  // Op uses the iterative divider.
  function automatic logic is_div_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_DIV, OP_DIVU: r = 1'b1;
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

  // Any real operation; NONE and unused encodings are never accepted.
  function automatic logic is_valid_op(input logic [3:0] op);
    return is_mult_op(op) | is_div_op(op);
  endfunction

  // Op treats its operands as two's complement.
  function automatic logic is_signed_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_MULT, OP_MADD, OP_MSUB, OP_MUL, OP_DIV: r = 1'b1;
      default:                                   r = 1'b0;
    endcase
    return r;
  endfunction

  // Op commits into HI/LO (everything except MUL, which writes a GPR).
  function automatic logic writes_hilo(input logic [3:0] op);
    return is_valid_op(op) & (op != OP_MUL);
  endfunction

  // Accumulate mode for the HI:LO update.
  function automatic logic [1:0] acc_sel_of(input logic [3:0] op);
    logic [1:0] r;
    case (op)
      OP_MADD, OP_MADDU: r = ACC_ADD;
      OP_MSUB, OP_MSUBU: r = ACC_SUB;
      default:           r = ACC_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mdu_seq_ctrl.sv
// EX-stage multiply/divide sequencer: owns multiplier/divider timing, the
// EX stall, the cancel/flush policy and the one-cycle commit enables.
module mdu_seq_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = 13
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       op_valid_i,
  input  logic [3:0] op_i,
  input  logic       stall_i,
  input  logic       flush_i,
  input  logic       except_i,
  input  logic       div_done_i,
  output logic       mult_ce_o,
  output logic       mult_signed_o,
  output logic       mult_sclr_o,
  output logic       div_start_o,
  output logic       div_signed_o,
  output logic       div_abort_o,
  output logic [1:0] acc_sel_o,
  output logic       stall_o,
  output logic       hi_we_o,
  output logic       lo_we_o,
  output logic       rd_we_o,
  output logic       busy_o
);

  localparam int CNT_W = $clog2(MULT_LAT + 1);
  // The accept cycle is the first CE cycle, so MUL_RUN lasts MULT_LAT-1
  // cycles; cnt counts MUL_RUN cycles from 0 and leaves on its last value.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_LAT - 2);

  mdu_state_e       state_r;
  mdu_state_e       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [3:0]       op_r;
  logic [3:0]       op_nxt_s;

  logic             accept_s;
  logic             cancel_s;
  logic             commit_s;
  logic [3:0]       cur_op_s;

  // Accept/cancel qualifiers; accept is gated by reset so outputs stay low
  // while rst_i is asserted.
  always_comb begin
    accept_s = rst_i & (state_r == ST_IDLE) & op_valid_i & is_valid_op(op_i)
             & ~flush_i & ~except_i;
    cancel_s = (state_r != ST_IDLE) & (flush_i | except_i);
    commit_s = (state_r == ST_DONE) & ~stall_i & ~flush_i & ~except_i;
    if (accept_s) begin
      cur_op_s = op_i;
    end else begin
      cur_op_s = op_r;
    end
  end

  // Next-state, counter and op-register update.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = {CNT_W{1'b0}};
    op_nxt_s    = op_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          op_nxt_s = op_i;
          if (is_mult_op(op_i)) begin
            state_nxt_s = ST_MUL_RUN;
          end else begin
            state_nxt_s = ST_DIV_RUN;
          end
        end else begin
          op_nxt_s = OP_NONE;
        end
      end
      ST_MUL_RUN: begin
        if (cancel_s) begin
          state_nxt_s = ST_IDLE;
          op_nxt_s    = OP_NONE;
        end else if (cnt_r >= CNT_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_DIV_RUN: begin
        if (cancel_s) begin
          state_nxt_s = ST_IDLE;
          op_nxt_s    = OP_NONE;
        end else if (div_done_i) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DIV_RUN;
        end
      end
      ST_DONE: begin
        if (cancel_s || !stall_i) begin
          state_nxt_s = ST_IDLE;
          op_nxt_s    = OP_NONE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        op_nxt_s    = OP_NONE;
      end
    endcase
  end

  // Resource controls, stall and commit enables.
  always_comb begin
    mult_ce_o     = 1'b0;
    mult_sclr_o   = 1'b0;
    div_start_o   = 1'b0;
    div_abort_o   = 1'b0;
    stall_o       = 1'b0;
    hi_we_o       = 1'b0;
    lo_we_o       = 1'b0;
    rd_we_o       = 1'b0;
    busy_o        = (state_r != ST_IDLE);
    mult_signed_o = is_mult_op(cur_op_s) & is_signed_op(cur_op_s);
    div_signed_o  = is_div_op(cur_op_s) & is_signed_op(cur_op_s);
    acc_sel_o     = acc_sel_of(cur_op_s);
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          mult_ce_o   = is_mult_op(op_i);
          div_start_o = is_div_op(op_i);
          stall_o     = 1'b1;
        end else begin
          stall_o     = 1'b0;
        end
      end
      ST_MUL_RUN: begin
        mult_ce_o   = 1'b1;
        stall_o     = 1'b1;
        mult_sclr_o = cancel_s;
      end
      ST_DIV_RUN: begin
        stall_o     = 1'b1;
        mult_sclr_o = cancel_s;
        div_abort_o = cancel_s;
      end
      ST_DONE: begin
        stall_o     = stall_i;
        mult_sclr_o = cancel_s;
        if (commit_s) begin
          hi_we_o = writes_hilo(op_r);
          lo_we_o = writes_hilo(op_r);
          rd_we_o = (op_r == OP_MUL);
        end else begin
          hi_we_o = 1'b0;
        end
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
  end

  // State, counter and latched-op registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      op_r    <= OP_NONE;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      op_r    <= op_nxt_s;
    end
  end

endmodule
